// File: rtl/tluh_32_pkg.sv
// ---------------------------------------------------------------------------
// tluh_32_pkg
// Purpose : TL-UL (32-bit data) bus types shared by host and device logic,
//           plus host-adapter helpers (outstanding limit, opcode selection).
// Contents: TL_* widths, tl_a_op_e / tl_d_op_e opcodes, tl_h2d_t / tl_d2h_t
//           channel bundles, tl_host_opcode(we, be).
// ---------------------------------------------------------------------------
package tluh_32_pkg;

    localparam int TL_AW  = 32;
    localparam int TL_DW  = 32;
    localparam int TL_AIW = 8;
    localparam int TL_DIW = 1;
    localparam int TL_DBW = TL_DW / 8;
    localparam int TL_SZW = 2;

    // Hard upper bound on outstanding requests for the host adapter
    localparam int TL_HOST_MAX_REQS_LIMIT = 4;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic              a_valid;
        tl_a_op_e          a_opcode;
        logic [2:0]        a_param;
        logic [TL_SZW-1:0] a_size;
        logic [TL_AIW-1:0] a_source;
        logic [TL_AW-1:0]  a_address;
        logic [TL_DBW-1:0] a_mask;
        logic [TL_DW-1:0]  a_data;
        logic [15:0]       a_user;
        logic              d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic              d_valid;
        tl_d_op_e          d_opcode;
        logic [2:0]        d_param;
        logic [TL_SZW-1:0] d_size;
        logic [TL_AIW-1:0] d_source;
        logic [TL_DIW-1:0] d_sink;
        logic [TL_DW-1:0]  d_data;
        logic [15:0]       d_user;
        logic              d_error;
        logic              a_ready;
    } tl_d2h_t;

    // Reads are Get; a write is a full put only when every byte lane is enabled
    function automatic tl_a_op_e tl_host_opcode(input logic we, input logic [TL_DBW-1:0] be);
        if (!we)                 return Get;
        else if (be == '1)       return PutFullData;
        else                     return PutPartialData;
    endfunction

endpackage

// File: rtl/tlul_host_adapter.sv
// ---------------------------------------------------------------------------
// tlul_host_adapter
// Purpose : Bridges a req/gnt/rvalid register-style master onto a TL-UL host
//           port. Up to MAX_REQS transactions may be in flight; responses are
//           expected in order and source IDs are issued round-robin.
// Ports   : clk_i, rst_i (async, active high)
//           req_i/gnt_o, we_i, addr_i, wdata_i, be_i   - master request side
//           valid_o, rdata_o, err_o                     - master response side
//           tl_o (tl_h2d_t), tl_i (tl_d2h_t)            - TL-UL host port
// Params  : MAX_REQS (1..4, <= 2**TL_AIW)
// Options : `define TLUL_HOST_SRC_CHECK_EN to check each D beat's d_source
//           against the expected in-order ID and flag a mismatch via err_o.
// ---------------------------------------------------------------------------
module tlul_host_adapter
    import tluh_32_pkg::*;
#(
    parameter int MAX_REQS = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  be_i,
    output logic        valid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output tl_h2d_t     tl_o,
    input  tl_d2h_t     tl_i
);

    localparam int IW = (MAX_REQS > 1) ? $clog2(MAX_REQS) : 1;
    localparam int CW = $clog2(MAX_REQS + 1);

    logic [IW-1:0] r_issue;
    logic [IW-1:0] r_retire;
    logic [CW-1:0] r_outst;
    logic          r_valid;
    logic [31:0]   r_rdata;
    logic          r_err;
    logic          spurious_q;

    logic w_a_valid;
    logic w_gnt;
    logic w_d_acc;
    logic w_src_err;
    logic w_unused;

    // Full check uses the registered count, so a slot freed by a response
    // only becomes grantable on the following cycle.
    assign w_a_valid = req_i && (r_outst < CW'(MAX_REQS));
    assign w_gnt     = w_a_valid && tl_i.a_ready;
    // A D beat with nothing outstanding has no owner and is dropped
    assign w_d_acc   = tl_i.d_valid && (r_outst != '0);

`ifdef TLUL_HOST_SRC_CHECK_EN
    assign w_src_err = (tl_i.d_source != {{(TL_AIW-IW){1'b0}}, r_retire});
    assign w_unused  = ^{tl_i.d_param, tl_i.d_size, tl_i.d_sink, tl_i.d_user};
`else
    assign w_src_err = 1'b0;
    assign w_unused  = ^{tl_i.d_param, tl_i.d_size, tl_i.d_sink, tl_i.d_user, tl_i.d_source};
`endif

    always_comb begin
        tl_o           = '0;
        tl_o.a_valid   = w_a_valid;
        tl_o.a_opcode  = tl_host_opcode(we_i, be_i);
        tl_o.a_param   = 3'd0;
        tl_o.a_size    = 2'd2;
        tl_o.a_source  = {{(TL_AIW-IW){1'b0}}, r_issue};
        tl_o.a_address = {addr_i[31:2], 2'b00};
        tl_o.a_mask    = be_i;
        tl_o.a_data    = wdata_i;
        tl_o.a_user    = '0;
        tl_o.d_ready   = 1'b1;
    end

    assign gnt_o   = w_gnt;
    assign valid_o = r_valid;
    assign rdata_o = r_rdata;
    assign err_o   = r_err;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_issue    <= '0;
            r_retire   <= '0;
            r_outst    <= '0;
            r_valid    <= 1'b0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            spurious_q <= 1'b0;
        end else begin
            if (w_gnt)
                r_issue <= (r_issue == IW'(MAX_REQS - 1)) ? '0 : r_issue + 1'b1;
            if (w_d_acc)
                r_retire <= (r_retire == IW'(MAX_REQS - 1)) ? '0 : r_retire + 1'b1;

            // Grant and retire in the same cycle cancel out
            case ({w_gnt, w_d_acc})
                2'b10:   r_outst <= r_outst + 1'b1;
                2'b01:   r_outst <= r_outst - 1'b1;
                default: r_outst <= r_outst;
            endcase

            r_valid <= w_d_acc;
            if (w_d_acc) begin
                r_rdata <= (tl_i.d_opcode == AccessAckData) ? tl_i.d_data : 32'h0;
                r_err   <= tl_i.d_error | w_src_err;
            end

            if (tl_i.d_valid && (r_outst == '0))
                spurious_q <= 1'b1;
        end
    end

    // A-channel valid may only fall after a handshake
    a_valid_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (tl_o.a_valid && !tl_i.a_ready) |=> tl_o.a_valid);

    // Master must hold request and payload until granted
    m_payload_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (req_i && !gnt_o) |=> (req_i && $stable({we_i, addr_i, wdata_i, be_i})));

endmodule

// File: tb/tb_tlul_host_adapter.sv
module tb_tlul_host_adapter;
    import tluh_32_pkg::*;

    localparam int MAX_REQS = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        gnt;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  be = '0;
    logic        valid;
    logic [31:0] rdata;
    logic        err;
    tl_h2d_t     tl_h;
    tl_d2h_t     tl_d;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    int outst = 0;
    int isrc  = 0;
    int rsrc  = 0;
    bit spur  = 0;
    bit last_gnt = 0;
    bit force_src = 0;

    always #5 clk = ~clk;

    tlul_host_adapter #(.MAX_REQS(MAX_REQS)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .we_i(we),
        .addr_i(addr), .wdata_i(wdata), .be_i(be), .valid_o(valid),
        .rdata_o(rdata), .err_o(err), .tl_o(tl_h), .tl_i(tl_d)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input bit r, input bit w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] b);
        req = r; we = w; addr = a; wdata = d; be = b;
    endtask

    task automatic set_d(input bit v, input tl_d_op_e op, input logic [31:0] d, input bit e);
        tl_d.d_valid = v; tl_d.d_opcode = op; tl_d.d_data = d; tl_d.d_error = e;
    endtask

    // One clock: check A-side combinationally, advance model, check response.
    task automatic step();
        bit av, g, acc;
        logic [31:0] e_rd;
        bit e_err;
        tl_a_op_e e_op;
        if (!force_src) tl_d.d_source = TL_AIW'(rsrc);
        #1;
        av  = req && (outst < MAX_REQS);
        g   = av && tl_d.a_ready;
        acc = tl_d.d_valid && (outst > 0);
        e_op = !we ? Get : ((be == 4'hF) ? PutFullData : PutPartialData);
        chk("a_valid", tl_h.a_valid, av);
        chk("gnt", gnt, g);
        chk("d_ready", tl_h.d_ready, 1);
        if (av) begin
            chk("a_address", tl_h.a_address, {addr[31:2], 2'b00});
            chk("a_opcode", tl_h.a_opcode, e_op);
            chk("a_source", tl_h.a_source, isrc);
            chk("a_mask", tl_h.a_mask, be);
            chk("a_data", tl_h.a_data, wdata);
            chk("a_size", tl_h.a_size, 2);
        end
        e_rd  = (tl_d.d_opcode == AccessAckData) ? tl_d.d_data : 32'h0;
        e_err = tl_d.d_error;
`ifdef TLUL_HOST_SRC_CHECK_EN
        if (tl_d.d_source != TL_AIW'(rsrc)) e_err = 1'b1;
`endif
        if (tl_d.d_valid && outst == 0) spur = 1'b1;
        @(posedge clk);
        outst = outst + int'(g) - int'(acc);
        isrc  = (isrc + int'(g)) % MAX_REQS;
        rsrc  = (rsrc + int'(acc)) % MAX_REQS;
        #1;
        chk("valid_o", valid, acc);
        if (acc) begin
            chk("rdata_o", rdata, e_rd);
            chk("err_o", err, e_err);
        end
        chk("spurious_q", dut.spurious_q, spur);
        last_gnt = g;
        @(negedge clk);
    endtask

    initial begin
        tl_d = '0;
        tl_d.a_ready = 1'b1;
        #12;
        // reset state
        chk("rst a_valid", tl_h.a_valid, 0);
        chk("rst gnt", gnt, 0);
        chk("rst valid_o", valid, 0);
        chk("rst rdata_o", rdata, 0);
        chk("rst err_o", err, 0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);

        // single read
        set_req(1, 0, 32'h1000_0006, 32'h0, 4'hF);
        step();
        set_req(0, 0, 0, 0, 0);
        set_d(1, AccessAckData, 32'hDEAD_BEEF, 0);
        step();
        set_d(0, AccessAck, 0, 0);
        step();

        // writes: full and partial, AccessAck zeroes rdata
        set_req(1, 1, 32'h2000_0010, 32'h1234_5678, 4'hF);
        step();
        set_req(1, 1, 32'h2000_0014, 32'hCAFE_F00D, 4'h3);
        set_d(1, AccessAck, 32'hFFFF_FFFF, 0);
        step();
        set_req(0, 0, 0, 0, 0);
        set_d(1, AccessAck, 32'hA5A5_A5A5, 0);
        step();
        set_d(0, AccessAck, 0, 0);
        step();

        // back-pressure: two grants, third held until a slot frees
        set_req(1, 0, 32'h3000_0000, 0, 4'hF); step();
        set_req(1, 0, 32'h3000_0004, 0, 4'hF); step();
        set_req(1, 0, 32'h3000_0008, 0, 4'hF); step();
        set_d(1, AccessAckData, 32'h1111_1111, 0); step();
        set_d(0, AccessAck, 0, 0); step();
        set_req(0, 0, 0, 0, 0);
        set_d(1, AccessAckData, 32'h2222_2222, 0); step();
        set_d(1, AccessAckData, 32'h3333_3333, 0); step();
        set_d(0, AccessAck, 0, 0);

        // simultaneous grant and response with one outstanding
        set_req(1, 0, 32'h4000_0000, 0, 4'hF); step();
        set_req(1, 0, 32'h4000_0004, 0, 4'hF);
        set_d(1, AccessAckData, 32'h4444_0000, 0); step();
        set_req(1, 1, 32'h4000_0008, 32'h55, 4'h1);
        set_d(0, AccessAck, 0, 0); step();
        set_req(0, 0, 0, 0, 0);
        set_d(1, AccessAckData, 32'h4444_0004, 0); step();
        set_d(1, AccessAck, 0, 0); step();
        set_d(0, AccessAck, 0, 0); step();

        // error pass-through
        set_req(1, 0, 32'h5000_0000, 0, 4'hF); step();
        set_req(0, 0, 0, 0, 0);
        set_d(1, AccessAckData, 32'hBAD0_BAD0, 1); step();
        set_d(0, AccessAck, 0, 0); step();

`ifdef TLUL_HOST_SRC_CHECK_EN
        // wrong source id forces an error
        set_req(1, 0, 32'h5000_0004, 0, 4'hF); step();
        set_req(0, 0, 0, 0, 0);
        force_src = 1'b1;
        tl_d.d_source = TL_AIW'(rsrc ^ 1);
        set_d(1, AccessAckData, 32'h0000_0042, 0); step();
        force_src = 1'b0;
        set_d(0, AccessAck, 0, 0); step();
`endif

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            if (!(req && !last_gnt)) begin
                set_req($urandom_range(0, 2) != 0, $urandom_range(0, 1), $urandom,
                        $urandom, 4'($urandom));
            end
            tl_d.a_ready = $urandom_range(0, 3) != 0;
            set_d($urandom_range(0, 2) == 0, tl_d_op_e'($urandom_range(0, 1)),
                  $urandom, $urandom_range(0, 7) == 0);
            step();
        end
        tl_d.a_ready = 1'b1;
        set_d(0, AccessAck, 0, 0);
        step();
        set_req(0, 0, 0, 0, 0);

        // reset mid-transaction, then a stray D beat
        set_req(1, 0, 32'h6000_0000, 0, 4'hF);
        while (outst < MAX_REQS) step();
        set_req(0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        chk("rst2 valid_o", valid, 0);
        chk("rst2 a_valid", tl_h.a_valid, 0);
        outst = 0; isrc = 0; rsrc = 0; spur = 0;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        set_d(1, AccessAckData, 32'h7777_7777, 0); step();
        set_d(0, AccessAck, 0, 0);
        set_req(1, 0, 32'h6000_0010, 0, 4'hF); step();
        set_req(0, 0, 0, 0, 0);
        set_d(1, AccessAckData, 32'h8888_8888, 0); step();
        set_d(0, AccessAck, 0, 0); step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tlul_host_adapter.md
Name: tlul_host_adapter

Overview:
- Converts a simple req/gnt/rvalid register-style master interface into a TL-UL host (A-channel initiator, D-channel consumer) on tluh_32_pkg types.
- It is the initiating end of the same bus the SPI peripheral's device-side logic and error responder answer on; SPI DMA and debug masters use it to reach the crossbar.
- Supports up to MAX_REQS outstanding transactions.
- Responses must return in order; source IDs are issued round-robin.

Parameters:
- MAX_REQS, 2, maximum outstanding transactions; legal range 1..4, and must not exceed 2**TL_AIW.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- req_i  in  1  master request; held stable with its payload until gnt_o
- gnt_o  out  1  request accepted this cycle
- we_i  in  1  1 = write, 0 = read
- addr_i  in  32  byte address; bits [1:0] ignored
- wdata_i  in  32  write data
- be_i  in  4  byte enables
- valid_o  out  1  response pulse, one cycle per accepted request
- rdata_o  out  32  read data, valid with valid_o
- err_o  out  1  response error, valid with valid_o
- tl_o  out  tl_h2d_t  TL-UL host-to-device bundle
- tl_i  in  tl_d2h_t  TL-UL device-to-host bundle

Behaviour:
- Reset (async assert, sync release): tl_o.a_valid=0; gnt_o=0; valid_o=0; rdata_o=0; err_o=0; issue/retire counters=0; outstanding count=0.
- Readiness: tl_o.d_ready is constant 1; the adapter never back-pressures D.
- A-channel, combinational from req_i:
  - a_valid = req_i & (outstanding < MAX_REQS).
  - a_address = {addr_i[31:2],2'b00}; a_size=2; a_mask=be_i; a_data=wdata_i; a_param=0; a_user=0.
  - Opcode: we_i=0 gives Get. we_i=1 with be_i==4'hF gives PutFullData. Any other write gives PutPartialData.
  - a_source = issue_cnt, zero-extended to TL_AIW.
- Grant: gnt_o = a_valid & tl_i.a_ready, combinational.
  - On gnt_o, issue_cnt increments modulo MAX_REQS.
  - With MAX_REQS=1, issue_cnt stays 0.
- Response:
  - On tl_i.d_valid, registered one cycle later: valid_o=1; rdata_o=tl_i.d_data; err_o=tl_i.d_error.
  - For AccessAck (write) responses, rdata_o=0.
  - retire_cnt increments modulo MAX_REQS.
  - Latency: D beat in cycle N gives valid_o in cycle N+1.
- Outstanding counter, width clog2(MAX_REQS+1):
  - +1 on gnt_o, -1 on d_valid.
  - Grant and response in the same cycle leave it unchanged.
  - When full, a_valid is forced low and gnt_o=0 until a response arrives. The freed slot is usable in the cycle after that response.
- Spurious response: d_valid with outstanding==0 is dropped.
  - No valid_o; counters unchanged.
  - Sticky internal flag spurious_q is set, visible to assertions.
- Reset mid-transaction: all in-flight transactions are abandoned.
  - D beats arriving after reset release with outstanding==0 fall under the spurious-response rule.
- Assertions:
  - a_valid must not drop without a_ready.
  - A payload change while req_i is high and gnt_o is low flags a master protocol violation.

Optional Feature:
- Macro: TLUL_HOST_SRC_CHECK_EN.
- Defined: each accepted D beat's d_source is compared to retire_cnt. On mismatch, the response is delivered with err_o forced to 1, regardless of d_error.
- Undefined: d_source is ignored, and err_o = d_error only.

Decomposition:
- tluh_32_pkg (existing) provides: tl_h2d_t, tl_d2h_t, tl_a_op_e, tl_d_op_e, TL_AIW.
- Add to the package: localparam TL_HOST_MAX_REQS_LIMIT = 4, and a function tl_host_opcode(we, be) returning tl_a_op_e.
- No sub-module: two modulo counters plus one up/down counter fit in one module.

Test Plan:
- Read, single: req_i=1, we_i=0, addr_i=32'h1000_0006, a_ready=1.
  - gnt_o in cycle 0 with a_address=32'h1000_0004, opcode Get, a_source=0.
  - Device returns d_data=32'hDEAD_BEEF next cycle, so valid_o=1 one cycle later with rdata_o=32'hDEAD_BEEF, err_o=0.
- Write opcode selection: be_i=4'hF gives PutFullData; be_i=4'h3 gives PutPartialData with a_mask=4'h3.
  - AccessAck response gives valid_o=1, rdata_o=0.
- Back-pressure and full (MAX_REQS=2): three back-to-back requests with D withheld.
  - Two grants with sources 0 then 1; third request gets gnt_o=0 and a_valid=0.
  - One D beat, then third grant the next cycle with source 0 (wrap).
- Simultaneous grant and response with outstanding=1: counter stays 1, and the next request is granted immediately.
- Error pass-through: d_error=1 gives err_o=1 and rdata_o=d_data.
  - With TLUL_HOST_SRC_CHECK_EN defined, d_source=1 when 0 is expected gives err_o=1 even with d_error=0.
- Reset and spurious: assert rst_i with 2 outstanding, release, then inject a d_valid beat.
  - No valid_o, outstanding stays 0, spurious_q=1; the next request is granted with source 0.
